// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. Operands are captured on an accepted
// START, added one bit per cycle LSB first, and the full {Cout,S} result is
// published with a one-cycle DONE pulse after WIDTH processing cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // One spare counter bit so the count can never wrap inside an operation.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             c;
  logic [CW-1:0]    cnt;

  logic accept, last, sum_bit, carry_nxt;

  // START is honoured whenever no addition is running (IDLE or FIN).
  assign accept    = START && (state != ADD);
  assign last      = (cnt == CW'(WIDTH - 1));
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ c;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; FIN doubles as the DONE cycle and may
  // chain straight into another addition.
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (START) state_nxt = ADD;
      end
      ADD: begin
        BUSY = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = START ? ADD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shift/add, and result publication.
  // S/Cout are written only on the final bit, so they hold the previous
  // result during a running addition.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      Cout <= 1'b0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      c    <= Cin;
      res  <= '0;
      cnt  <= '0;
    end else if (state == ADD) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      c    <= carry_nxt;
      res  <= {sum_bit, res[WIDTH-1:1]};
      cnt  <= cnt + 1'b1;
      if (last) begin
        S    <= {sum_bit, res[WIDTH-1:1]};
        Cout <= carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=16 instances side by side, a
// cycle-timed transaction model of both, per-cycle output comparison, and
// directed scenarios with literal expectations.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        st8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  s8;

  logic        st16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] s16;

  serial_adder #(.WIDTH(8)) u8 (
    .CLK(clk), .RST_N(rst_n), .START(st8), .A(a8), .B(b8), .Cin(cin8),
    .BUSY(busy8), .DONE(done8), .S(s8), .Cout(cout8)
  );

  serial_adder #(.WIDTH(16)) u16 (
    .CLK(clk), .RST_N(rst_n), .START(st16), .A(a16), .B(b16), .Cin(cin16),
    .BUSY(busy16), .DONE(done16), .S(s16), .Cout(cout16)
  );

  initial forever #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an addition accepted at edge n publishes A+B+Cin at
  // edge n+W; it is busy after edges n..n+W-1 and DONE after edge n+W.
  int          ec = 0;
  int          acc[2]  = '{-1, -1};
  int          nacc[2] = '{0, 0};
  logic [16:0] res[2]  = '{17'd0, 17'd0};
  logic [16:0] out[2]  = '{17'd0, 17'd0};

  initial forever begin
    int          w;
    logic        s;
    logic [16:0] sum;
    bit          busy_before;
    @(posedge clk);
    ec++;
    for (int k = 0; k < 2; k++) begin
      w   = (k == 0) ? 8 : 16;
      s   = (k == 0) ? st8 : st16;
      sum = (k == 0) ? 17'(a8) + 17'(b8) + 17'(cin8)
                     : 17'(a16) + 17'(b16) + 17'(cin16);
      busy_before = (acc[k] >= 0) && (ec - 1 >= acc[k]) && (ec - 1 < acc[k] + w);
      if (!rst_n) begin
        acc[k] = -1;
        out[k] = '0;
      end else begin
        if (acc[k] >= 0 && ec == acc[k] + w) out[k] = res[k];
        if (s && !busy_before) begin
          acc[k] = ec;
          res[k] = sum;
          nacc[k]++;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    bit eb, ed;
    @(negedge clk);
    if (chk_en) begin
      eb = (acc[0] >= 0) && (ec >= acc[0]) && (ec < acc[0] + 8);
      ed = (acc[0] >= 0) && (ec == acc[0] + 8);
      chk("u8 BUSY", busy8, eb);
      chk("u8 DONE", done8, ed);
      chk("u8 S", s8, out[0][7:0]);
      chk("u8 Cout", cout8, out[0][8]);
      eb = (acc[1] >= 0) && (ec >= acc[1]) && (ec < acc[1] + 16);
      ed = (acc[1] >= 0) && (ec == acc[1] + 16);
      chk("u16 BUSY", busy16, eb);
      chk("u16 DONE", done16, ed);
      chk("u16 S", s16, out[1][15:0]);
      chk("u16 Cout", cout16, out[1][16]);
    end
  end

  // One WIDTH=8 addition; operands are scrambled once accepted.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp, input string nm);
    int k;
    st8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk({nm, " busy"}, busy8, 1);
    k = 0;
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, 8);
    chk({nm, " result"}, {cout8, s8}, exp);
    chk({nm, " model"}, out[0][8:0], exp);
    @(negedge clk);
  endtask

  initial begin
    int k, dn, base0, base1;
    bit ok8, ok16;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset BUSY", busy8, 0);
    chk("reset DONE", done8, 0);
    chk("reset S", s8, 0);
    chk("reset Cout", cout8, 0);

    rst_n = 1'b1;
    op8(8'h5A, 8'h3C, 1'b0, 9'h096, "5A+3C");
    op8(8'hFF, 8'h01, 1'b0, 9'h100, "FF+01");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "FF+FF+1");

    // START held through the addition with changing operands.
    st8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8) dn++;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end
    @(negedge clk);
    chk("hold early DONE count", dn, 0);
    chk("hold first DONE", done8, 1);
    chk("hold first result", {cout8, s8}, 9'h096);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1;
    @(negedge clk);
    chk("b2b DONE drop", done8, 0);
    chk("b2b accept", busy8, 1);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    k = 0;
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b latency", k, 8);
    chk("b2b result", {cout8, s8}, 9'h034);
    @(negedge clk);

    // Reset at the fourth edge of a running addition.
    st8 = 1'b1; a8 = 8'hC3; b8 = 8'h77; cin8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort BUSY", busy8, 0);
    chk("abort S", s8, 0);
    chk("abort Cout", cout8, 0);
    @(negedge clk);
    chk("abort DONE", done8, 0);
    rst_n = 1'b1;
    op8(8'h01, 8'h02, 1'b0, 9'h003, "post-reset 01+02");

    // Random sweep on both widths, START and operands churning every cycle.
    base0 = nacc[0];
    base1 = nacc[1];
    ok8 = 0;
    ok16 = 0;
    fork
      begin
        int cyc = 0;
        while (nacc[0] - base0 < 1000 && cyc < 40000) begin
          @(negedge clk);
          st8  = ($urandom_range(7) != 0);
          a8   = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
          b8   = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
          cin8 = 1'($urandom);
          cyc++;
        end
        ok8 = (nacc[0] - base0 >= 1000);
        st8 = 1'b0;
      end
      begin
        int cyc = 0;
        while (nacc[1] - base1 < 1000 && cyc < 40000) begin
          @(negedge clk);
          st16  = ($urandom_range(7) != 0);
          a16   = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
          b16   = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
          cin16 = 1'($urandom);
          cyc++;
        end
        ok16 = (nacc[1] - base1 >= 1000);
        st16 = 1'b0;
      end
    join
    chk("u8 sweep completed", ok8, 1);
    chk("u16 sweep completed", ok16, 1);
    repeat (24) @(negedge clk);
    chk("u8 idle at end", busy8, 0);
    chk("u16 idle at end", busy16, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
